err_compute_ctrl: RTL and testbench

- Control sequencer that drives the weighted-IR error datapath: sel, sub, clr_accum, en_accum and err_vld.
- Each IR_vld request starts one pass:
  - settle delay
  - accumulator clear
  - eight accumulate terms in order R0, L0, R1, L1, R2, L2, R3, L3
  - one-cycle err_vld strobe when the datapath error output is valid
- Sits between the IR sensor sampling logic and err_compute_DP.

---
 rtl/err_compute_ctrl.sv | 152 +++++++++++++++
 tb/tb_err_compute_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/err_compute_ctrl.sv
// Control sequencer for the weighted-IR error datapath: settle, clear, eight accumulate terms, error strobe.
// Optional one-deep pending request is enabled by defining ERR_COMPUTE_PEND_EN.
module err_compute_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IR_vld,
    input  logic       clr_ovr,
    output logic [2:0] sel,
    output logic       sub,
    output logic       clr_accum,
    output logic       en_accum,
    output logic       err_vld,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CLR    = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic       SKIP_SETTLE = (SETTLE == 32'sd0);
    localparam logic [3:0] SETTLE_LD   = (SETTLE > 32'sd0) ? 4'(SETTLE - 32'sd1) : 4'd0;

    state_t     state_r;
    state_t     state_nx_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nx_s;
    logic [2:0] sel_nx_s;
    logic       busy_req_s;
    logic       loss_s;
    logic       relaunch_s;
    logic       start_s;
`ifdef ERR_COMPUTE_PEND_EN
    logic       pending_r;
    logic       pend_req_s;
`endif

    // Request classification: accepted, deferred into pending, or lost.
    always_comb begin
        busy_req_s = IR_vld && (state_r != ST_IDLE);
`ifdef ERR_COMPUTE_PEND_EN
        pend_req_s = busy_req_s && !pending_r;
        loss_s     = busy_req_s && pending_r;
        relaunch_s = (state_r == ST_DONE) && (pending_r || pend_req_s);
`else
        loss_s     = busy_req_s;
        relaunch_s = 1'b0;
`endif
        start_s    = ((state_r == ST_IDLE) && IR_vld) || relaunch_s;
    end

    // Next-state, settle count and term select.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        sel_nx_s   = 3'd0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    if (SKIP_SETTLE) begin
                        state_nx_s = ST_CLR;
                    end else begin
                        state_nx_s = ST_SETTLE;
                        cnt_nx_s   = SETTLE_LD;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = ST_CLR;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_CLR: begin
                state_nx_s = ST_ACCUM;
            end
            ST_ACCUM: begin
                // No wrap: the last term hands over to DONE with sel back at 0.
                if (sel == 3'd7) begin
                    state_nx_s = ST_DONE;
                end else begin
                    sel_nx_s = sel + 3'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // State register with Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            sel       <= 3'd0;
            sub       <= 1'b0;
            clr_accum <= 1'b0;
            en_accum  <= 1'b0;
            err_vld   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            sel       <= sel_nx_s;
            sub       <= sel_nx_s[0];
            clr_accum <= (state_nx_s == ST_CLR);
            en_accum  <= (state_nx_s == ST_ACCUM);
            err_vld   <= (state_nx_s == ST_DONE);
            busy      <= (state_nx_s != ST_IDLE);
        end
    end

`ifdef ERR_COMPUTE_PEND_EN
    // One-deep pending request; consumed when DONE relaunches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (relaunch_s) begin
            pending_r <= 1'b0;
        end else if (pend_req_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end
`endif

    // Sticky overrun; a new loss beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (loss_s) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun;
        end
    end

endmodule

// File: tb/tb_err_compute_ctrl.sv
// Scoreboard bench for err_compute_ctrl: per-cycle expected output vectors queued by stimulus, checked by a monitor.
module tb_err_compute_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, IR_vld, clr_ovr;
    logic [2:0] sel2, sel0;
    logic sub2, clr2, en2, err2, busy2, ovr2;
    logic sub0, clr0, en0, err0, busy0, ovr0;

    err_compute_ctrl #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .IR_vld(IR_vld), .clr_ovr(clr_ovr),
        .sel(sel2), .sub(sub2), .clr_accum(clr2), .en_accum(en2),
        .err_vld(err2), .busy(busy2), .overrun(ovr2)
    );

    err_compute_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .IR_vld(IR_vld), .clr_ovr(clr_ovr),
        .sel(sel0), .sub(sub0), .clr_accum(clr0), .en_accum(en0),
        .err_vld(err0), .busy(busy0), .overrun(ovr0)
    );

    // Vector layout: {busy, overrun, clr_accum, en_accum, err_vld, sel[2:0], sub}
    logic [8:0] obs2, obs0;
    assign obs2 = {busy2, ovr2, clr2, en2, err2, sel2, sub2};
    assign obs0 = {busy0, ovr0, clr0, en0, err0, sel0, sub0};

    typedef struct {
        int         scen;
        int         cyc;
        logic [8:0] v;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         scen  = 0;
    int         s_cur = 2;
    bit         use0  = 1'b0;
    logic [8:0] ev[64];
    logic       ir_t[64];
    logic       co_t[64];
    logic       rst_t[64];

    // Monitor: pops one expectation per cycle and compares at the falling edge.
    initial begin
        exp_t       cur;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                cur = q.pop_front();
                got = use0 ? obs0 : obs2;
                total++;
                if (got !== cur.v) begin
                    bad++;
                    $display("FAIL scen%0d cycle%0d busy/ovr/clr/en/err/sel/sub: got %b_%b_%b_%b_%b_%03b_%b want %b_%b_%b_%b_%b_%03b_%b",
                             cur.scen, cur.cyc, got[8], got[7], got[6], got[5], got[4], got[3:1], got[0],
                             cur.v[8], cur.v[7], cur.v[6], cur.v[5], cur.v[4], cur.v[3:1], cur.v[0]);
                end
            end
        end
    end

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) begin
            ev[i]    = 9'd0;
            ir_t[i]  = 1'b0;
            co_t[i]  = 1'b0;
            rst_t[i] = 1'b0;
        end
    endtask

    // Expected trace of one pass whose request is sampled at edge k.
    task automatic add_pass(input int k);
        int c;
        for (int i = k + 1; i <= k + 10 + s_cur; i++) ev[i][8] = 1'b1;
        ev[k + 1 + s_cur][6] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c = k + 2 + s_cur + i;
            ev[c][5]   = 1'b1;
            ev[c][3:1] = 3'(i);
            ev[c][0]   = i[0];
        end
        ev[k + 10 + s_cur][4] = 1'b1;
    endtask

    task automatic set_ovr(input int a, input int b);
        for (int i = a; i <= b; i++) ev[i][7] = 1'b1;
    endtask

    task automatic zero_exp(input int a, input int b);
        for (int i = a; i <= b; i++) ev[i] = 9'd0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        IR_vld  = 1'b0;
        clr_ovr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives edges 0..n-1 from the tables and queues the expectation for cycles 1..n.
    task automatic run(input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst     = 1'b0;
            IR_vld  = ir_t[c];
            clr_ovr = co_t[c];
            @(posedge clk);
            #1;
            e.scen = scen;
            e.cyc  = c + 1;
            e.v    = ev[c + 1];
            q.push_back(e);
            if (rst_t[c]) begin
                #1 rst = 1'b1;
            end
        end
        @(negedge clk);
        IR_vld  = 1'b0;
        clr_ovr = 1'b0;
        rst     = 1'b0;
        for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL scen%0d drain: got %0d pending want 0", scen, q.size());
            q.delete();
        end
    endtask

    initial begin
        exp_t e;
        rst     = 1'b1;
        IR_vld  = 1'b0;
        clr_ovr = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        e.scen = 0; e.cyc = 0; e.v = 9'd0;
        q.push_back(e);
        @(negedge clk);
        @(negedge clk);

        // Basic pass, SETTLE=2
        scen = 1; s_cur = 2; use0 = 1'b0;
        do_reset(); clear_exp();
        ir_t[0] = 1'b1;
        add_pass(0);
        run(16);

        // SETTLE=0 instance
        scen = 2; s_cur = 0; use0 = 1'b1;
        do_reset(); clear_exp();
        ir_t[0] = 1'b1;
        add_pass(0);
        run(12);

        // Reset while sel=4, then a fresh pass
        scen = 3; s_cur = 2; use0 = 1'b0;
        do_reset(); clear_exp();
        ir_t[0]  = 1'b1;
        rst_t[7] = 1'b1;
        ir_t[10] = 1'b1;
        add_pass(0);
        zero_exp(8, 12);
        add_pass(10);
        run(24);

        // Busy-time requests at edges 5 and 7, clr_ovr with the loss at 7, clear at 26
        scen = 4;
        do_reset(); clear_exp();
        ir_t[0] = 1'b1; ir_t[5] = 1'b1; ir_t[7] = 1'b1;
        co_t[7] = 1'b1; co_t[26] = 1'b1;
        add_pass(0);
`ifdef ERR_COMPUTE_PEND_EN
        add_pass(12);
        set_ovr(8, 26);
`else
        set_ovr(6, 26);
`endif
        run(30);

        // Request sampled in the DONE cycle
        scen = 5;
        do_reset(); clear_exp();
        ir_t[0] = 1'b1; ir_t[12] = 1'b1;
        add_pass(0);
`ifdef ERR_COMPUTE_PEND_EN
        add_pass(12);
`else
        set_ovr(13, 28);
`endif
        run(28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
